// File: rtl/ahblite_interconnect_slaveport.sv
// Slave-side port of an AHB-Lite multi-layer interconnect (one instance per slave).
// Arbitrates among the masters that address this slave (round-robin, lock aware),
// muxes the owner's address phase and the data-phase owner's write data onto the
// slave, and routes the slave response back to the master owning the data phase.
//
// Handshake: a transfer phase completes on a rising HCLK edge where the slave's
// HREADYOUT is high. A master seeing HREADY low must hold its address/control
// (and write data) stable until HREADY is seen high.
module ahblite_interconnect_slaveport #(
    parameter int MASTER      = 2,
    parameter int HADDR_WIDTH = 32,
    parameter int HDATA_WIDTH = 32
) (
    input  logic                                   HCLK,
    input  logic                                   HRESET,
    input  logic [MASTER-1:0]                      mst_HSEL_i,
    input  logic [MASTER-1:0]                      mst_switch_i,
    input  logic [MASTER-1:0][1:0]                 mst_HTRANS_i,
    input  logic [MASTER-1:0][2:0]                 mst_HBURST_i,
    input  logic [MASTER-1:0][2:0]                 mst_HSIZE_i,
    input  logic [MASTER-1:0]                      mst_HWRITE_i,
    input  logic [MASTER-1:0][HADDR_WIDTH-1:0]     mst_HADDR_i,
    input  logic [MASTER-1:0][HDATA_WIDTH-1:0]     mst_HWDATA_i,
    input  logic [MASTER-1:0]                      mst_HMASTLOCK_i,
    input  logic [MASTER-1:0][6:0]                 mst_HPROT_i,
    input  logic [MASTER-1:0]                      mst_HNONSEC_i,
    input  logic [MASTER-1:0]                      mst_HEXCL_i,
    input  logic [MASTER-1:0][3:0]                 mst_HMASTER_i,
    output logic [MASTER-1:0]                      mst_grant_o,
    output logic [MASTER-1:0]                      mst_HREADY_o,
    output logic [MASTER-1:0][HDATA_WIDTH-1:0]     mst_HRDATA_o,
    output logic [MASTER-1:0]                      mst_HRESP_o,
    output logic [MASTER-1:0]                      mst_HEXOKAY_o,
    output logic                                   slv_HSEL_o,
    output logic [1:0]                             slv_HTRANS_o,
    output logic [2:0]                             slv_HBURST_o,
    output logic [2:0]                             slv_HSIZE_o,
    output logic                                   slv_HWRITE_o,
    output logic [HADDR_WIDTH-1:0]                 slv_HADDR_o,
    output logic                                   slv_HMASTLOCK_o,
    output logic [6:0]                             slv_HPROT_o,
    output logic                                   slv_HNONSEC_o,
    output logic                                   slv_HEXCL_o,
    output logic [3:0]                             slv_HMASTER_o,
    output logic [HDATA_WIDTH-1:0]                 slv_HWDATA_o,
    output logic                                   slv_HREADY_o,
    input  logic [HDATA_WIDTH-1:0]                 slv_HRDATA_i,
    input  logic                                   slv_HREADYOUT_i,
    input  logic                                   slv_HRESP_i,
    input  logic                                   slv_HEXOKAY_i
);

    localparam int         IDX_W         = (MASTER > 1) ? $clog2(MASTER) : 1;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    logic [MASTER-1:0] owner;
    logic [IDX_W-1:0]  owner_idx;
    logic [IDX_W-1:0]  rr_ptr;
    logic              lock_hold;
    logic              dph_valid;
    logic [IDX_W-1:0]  dph_owner;

    logic [MASTER-1:0] req;
    logic              arb_point;
    logic              rr_found;
    logic [IDX_W-1:0]  rr_next;
    logic [MASTER-1:0] owner_nxt;
    logic              addr_active;

    // Index of the master that is 'off' positions after 'base', wrapping at MASTER.
    function automatic logic [IDX_W-1:0] wrap_idx(input int base, input int off);
        int s;
        s = (base + off) % MASTER;
        return IDX_W'(s);
    endfunction

    // Encode the one-hot owner into an index used by all muxes.
    always_comb begin
        owner_idx = '0;
        for (int m = 0; m < MASTER; m++) begin
            if (owner[m]) owner_idx = IDX_W'(m);
        end
    end

    // Requests are new transfers only; bursts continue under the current owner.
    always_comb begin
        req = '0;
        for (int m = 0; m < MASTER; m++) begin
            req[m] = mst_HSEL_i[m] && (mst_HTRANS_i[m] == HTRANS_NONSEQ);
        end
    end

    assign arb_point = slv_HREADYOUT_i && mst_switch_i[owner_idx] && !lock_hold;

    // Round-robin search for the first requester after the last-granted master.
    always_comb begin
        rr_found  = 1'b0;
        rr_next   = rr_ptr;
        owner_nxt = '0;
        for (int i = 1; i <= MASTER; i++) begin
            if (!rr_found && req[wrap_idx(int'(rr_ptr), i)]) begin
                rr_found = 1'b1;
                rr_next  = wrap_idx(int'(rr_ptr), i);
            end
        end
        owner_nxt[rr_next] = 1'b1;
    end

    // Address-phase mux driven by the current owner.
    assign slv_HSEL_o      = mst_HSEL_i[owner_idx];
    assign slv_HTRANS_o    = mst_HSEL_i[owner_idx] ? mst_HTRANS_i[owner_idx] : HTRANS_IDLE;
    assign slv_HBURST_o    = mst_HBURST_i[owner_idx];
    assign slv_HSIZE_o     = mst_HSIZE_i[owner_idx];
    assign slv_HWRITE_o    = mst_HWRITE_i[owner_idx];
    assign slv_HADDR_o     = mst_HADDR_i[owner_idx];
    assign slv_HMASTLOCK_o = mst_HMASTLOCK_i[owner_idx];
    assign slv_HPROT_o     = mst_HPROT_i[owner_idx];
    assign slv_HNONSEC_o   = mst_HNONSEC_i[owner_idx];
    assign slv_HEXCL_o     = mst_HEXCL_i[owner_idx];
    assign slv_HMASTER_o   = mst_HMASTER_i[owner_idx];
    assign slv_HREADY_o    = slv_HREADYOUT_i;
    assign addr_active     = slv_HSEL_o && slv_HTRANS_o[1];

    // Write data follows the data-phase owner, not the address-phase owner.
    assign slv_HWDATA_o    = mst_HWDATA_i[dph_owner];
    assign mst_grant_o     = owner;
    assign mst_HRDATA_o    = {MASTER{slv_HRDATA_i}};

    // Ownership, round-robin pointer, bus lock and data-phase tracking.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            owner     <= {{(MASTER-1){1'b0}}, 1'b1};
            rr_ptr    <= '0;
            lock_hold <= 1'b0;
            dph_valid <= 1'b0;
            dph_owner <= '0;
        end else begin
            if (arb_point && rr_found) begin
                owner  <= owner_nxt;
                rr_ptr <= rr_next;
            end
            if (slv_HREADYOUT_i) begin
                if (addr_active) lock_hold <= mst_HMASTLOCK_i[owner_idx];
                dph_valid <= addr_active;
                dph_owner <= owner_idx;
            end
        end
    end

    // Response routing: data-phase owner sees the slave, waiting requesters stall.
    always_comb begin
        mst_HREADY_o  = '1;
        mst_HRESP_o   = '0;
        mst_HEXOKAY_o = '0;
        for (int m = 0; m < MASTER; m++) begin
            if (dph_valid && (dph_owner == IDX_W'(m))) begin
                mst_HREADY_o[m]  = slv_HREADYOUT_i;
                mst_HRESP_o[m]   = slv_HRESP_i;
                mst_HEXOKAY_o[m] = slv_HEXOKAY_i;
            end else if (req[m] && !owner[m]) begin
                mst_HREADY_o[m]  = 1'b0;
            end
        end
    end

endmodule
